// File: rtl/intctrl_vec_if.sv
// if_wb: 32-bit Wishbone classic bus shared by an IO-decoder master and register slaves.
interface if_wb;
  logic [31:0] adr;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic [3:0]  sel;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        ack;
  modport master (output adr, dat_i, sel, cyc, stb, we, input dat_o, ack);
  modport slave (input adr, dat_i, sel, cyc, stb, we, output dat_o, ack);
endinterface

// File: rtl/intctrl_vec.sv
// intctrl_vec: prioritised interrupt vector encoder with per-source mask, level/edge mode,
// latched pending bits, an in-service state machine and Wishbone register access.
module intctrl_vec #(
  parameter int NSRC = 8,
  parameter int VECW = 4,
  parameter int SYNC = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  if_wb.slave             bus,
  input  logic [NSRC-1:0] src,
  input  logic            enabled,
  output logic [VECW-1:0] cpu_exception,
  output logic            irq_pending
);
  typedef enum logic [1:0] {IDLE = 2'd0, ASSERT = 2'd1, SERVICE = 2'd2} state_t;
  state_t          state, state_nx;
  logic [NSRC-1:0] sync_q [SYNC];
  logic [NSRC-1:0] s, s_d, rise, pend, pend_nx, mask, mode, elig, clr, svc_clr, wd, wm;
  logic [VECW-1:0] vec, vec_nx, win;
  logic [31:0]     bmask, rdata;
  logic            acc, wr;
  assign s       = sync_q[SYNC-1];
  assign rise    = s & ~s_d;
  assign elig    = pend & mask;
  assign acc     = bus.cyc & bus.stb & ~bus.ack;
  assign wr      = bus.cyc & bus.stb & bus.we & bus.ack;
  assign bmask   = {{8{bus.sel[3]}}, {8{bus.sel[2]}}, {8{bus.sel[1]}}, {8{bus.sel[0]}}};
  assign wm      = bmask[NSRC-1:0];
  assign wd      = bus.dat_i[NSRC-1:0];
  assign clr     = (wr && bus.adr[3:2] == 2'd0 ? wd & wm : '0) | svc_clr;
  // set beats clear for edge bits; level bits simply mirror the synchronised input
  assign pend_nx = (~mode & s) | (mode & ((pend & ~clr) | rise));
  always_comb begin
    win = '0;
    for (int i = NSRC - 1; i >= 0; i--) if (elig[i]) win = VECW'(i + 1);
  end
  always_comb begin
    state_nx = state;
    vec_nx   = vec;
    svc_clr  = '0;
    case (state)
      IDLE: if (enabled && |elig) begin
        state_nx = ASSERT;
        vec_nx   = win;
      end
      ASSERT: if (~|elig) state_nx = IDLE;
      else if (!enabled) begin
        state_nx = SERVICE;
        svc_clr  = mode & (NSRC'(1) << (vec - VECW'(1)));
      end
      else if (win < vec) vec_nx = win;
      SERVICE: if (enabled) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    rdata = '0;
    case (bus.adr[3:2])
      2'd0: rdata[NSRC-1:0] = pend;
      2'd1: rdata[NSRC-1:0] = mask;
      2'd2: rdata[NSRC-1:0] = mode;
      default: begin
        rdata[1:0]  = state;
        rdata[15:8] = 8'(vec);
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      for (int i = 0; i < SYNC; i++) sync_q[i] <= '0;
      s_d           <= '0;
      pend          <= '0;
      mask          <= '0;
      mode          <= '0;
      state         <= IDLE;
      vec           <= '0;
      cpu_exception <= '0;
      irq_pending   <= 1'b0;
      bus.ack       <= 1'b0;
      bus.dat_o     <= '0;
    end else begin
      sync_q[0] <= src;
      for (int i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
      s_d           <= s;
      pend          <= pend_nx;
      if (wr && bus.adr[3:2] == 2'd1) mask <= (mask & ~wm) | (wd & wm);
      if (wr && bus.adr[3:2] == 2'd2) mode <= (mode & ~wm) | (wd & wm);
      state         <= state_nx;
      vec           <= vec_nx;
      cpu_exception <= state == ASSERT ? vec : '0;
      irq_pending   <= |elig;
      bus.ack       <= acc;
      if (acc) bus.dat_o <= rdata;
    end
endmodule

// File: tb/tb_intctrl_vec.sv
// tb_intctrl_vec: directed self-checking bench for intctrl_vec (NSRC=8, VECW=4, SYNC=2).
module tb_intctrl_vec;
  logic       clk = 1'b0;
  logic       rst_ni;
  logic [7:0] src;
  logic       enabled;
  logic [3:0] cpu_exception;
  logic       irq_pending;
  logic [31:0] rd;
  int n_chk = 0;
  int n_fail = 0;
  if_wb bus ();
  intctrl_vec #(.NSRC(8), .VECW(4), .SYNC(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .bus(bus), .src(src), .enabled(enabled),
    .cpu_exception(cpu_exception), .irq_pending(irq_pending)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_ack();
    int n = 0;
    do begin
      tick();
      n++;
    end while (bus.ack !== 1'b1 && n < 8);
    check("ack_seen", {31'd0, bus.ack}, 32'd1);
  endtask
  task automatic wb_write(input logic [1:0] r, input logic [31:0] d, input logic [3:0] sel);
    bus.adr = {28'd0, r, 2'b00};
    bus.dat_i = d;
    bus.sel = sel;
    bus.we = 1'b1;
    bus.cyc = 1'b1;
    bus.stb = 1'b1;
    wait_ack();
    tick();
    check("ack_pulse_wr", {31'd0, bus.ack}, 32'd0);
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    bus.we = 1'b0;
  endtask
  task automatic wb_read(input logic [1:0] r, output logic [31:0] d);
    bus.adr = {28'd0, r, 2'b00};
    bus.sel = 4'hF;
    bus.we = 1'b0;
    bus.cyc = 1'b1;
    bus.stb = 1'b1;
    wait_ack();
    d = bus.dat_o;
    tick();
    check("ack_pulse_rd", {31'd0, bus.ack}, 32'd0);
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
  endtask
  task automatic check_reg(input string tag, input logic [1:0] r, input logic [31:0] exp);
    logic [31:0] v;
    wb_read(r, v);
    check(tag, v, exp);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst_ni = 1'b0;
    src = '0;
    enabled = 1'b0;
    bus.adr = '0;
    bus.dat_i = '0;
    bus.sel = '0;
    bus.we = 1'b0;
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    tick(3);
    check("rst_cpu_exc", 32'(cpu_exception), 32'd0);
    check("rst_irq_pending", {31'd0, irq_pending}, 32'd0);
    check("rst_ack", {31'd0, bus.ack}, 32'd0);
    rst_ni = 1'b1;
    tick();
    check_reg("rst_mask", 2'd1, 32'h0);
    check_reg("rst_status", 2'd3, 32'h0);
    // byte lane 1 carries nothing for 8 sources
    wb_write(2'd1, 32'h0000_FFFF, 4'h2);
    check_reg("mask_sel_ignored", 2'd1, 32'h0);
    wb_write(2'd1, 32'h0000_00FF, 4'hF);
    wb_write(2'd2, 32'h0000_00FF, 4'hF);
    check_reg("mask_rw", 2'd1, 32'hFF);
    check_reg("mode_rw", 2'd2, 32'hFF);
    enabled = 1'b1;
    src = 8'h08;
    tick();
    src = 8'h00;
    tick(3);
    check("latency_early", 32'(cpu_exception), 32'd0);
    tick();
    check("edge_vec4", 32'(cpu_exception), 32'd4);
    check("irq_pending_set", {31'd0, irq_pending}, 32'd1);
    check_reg("pending_08", 2'd0, 32'h08);
    check_reg("status_assert", 2'd3, 32'h0401);
    enabled = 1'b0;
    tick(2);
    check("service_cpu0", 32'(cpu_exception), 32'd0);
    check_reg("status_service", 2'd3, 32'h0402);
    check_reg("pending_cleared", 2'd0, 32'h0);
    check("irq_pending_clr", {31'd0, irq_pending}, 32'd0);
    enabled = 1'b1;
    tick();
    check_reg("status_idle", 2'd3, 32'h0400);
    src = 8'h24;
    tick(5);
    check("prio_vec3", 32'(cpu_exception), 32'd3);
    enabled = 1'b0;
    tick(2);
    check("prio_service", 32'(cpu_exception), 32'd0);
    check_reg("pending_20", 2'd0, 32'h20);
    enabled = 1'b1;
    tick(3);
    check("prio_vec6", 32'(cpu_exception), 32'd6);
    src = 8'h00;
    enabled = 1'b0;
    tick(2);
    enabled = 1'b1;
    tick(2);
    check_reg("pending_empty", 2'd0, 32'h0);
    wb_write(2'd2, 32'h0, 4'hF);
    wb_write(2'd1, 32'h01, 4'hF);
    src = 8'h01;
    tick(5);
    check("level_vec1", 32'(cpu_exception), 32'd1);
    wb_write(2'd0, 32'h01, 4'hF);
    check("level_w1c_cpu", 32'(cpu_exception), 32'd1);
    check_reg("level_w1c_pend", 2'd0, 32'h01);
    src = 8'h00;
    tick(6);
    check("level_drop_cpu0", 32'(cpu_exception), 32'd0);
    check_reg("level_drop_idle", 2'd3, 32'h0100);
    wb_write(2'd2, 32'h02, 4'hF);
    src = 8'h02;
    tick(4);
    check_reg("edge1_pend", 2'd0, 32'h02);
    wb_write(2'd0, 32'h02, 4'hF);
    check_reg("w1c_clears", 2'd0, 32'h0);
    src = 8'h00;
    tick(3);
    src = 8'h02;
    tick();
    wb_write(2'd0, 32'h02, 4'hF);
    check_reg("set_beats_clear", 2'd0, 32'h02);
    wb_write(2'd1, 32'h02, 4'hF);
    tick(2);
    check("pre_reset_vec2", 32'(cpu_exception), 32'd2);
    check("pre_reset_irq", {31'd0, irq_pending}, 32'd1);
    #3;
    rst_ni = 1'b0;
    #1;
    check("async_rst_cpu", 32'(cpu_exception), 32'd0);
    check("async_rst_irq", {31'd0, irq_pending}, 32'd0);
    check("async_rst_mask", 32'(dut.mask), 32'd0);
    tick(2);
    rst_ni = 1'b1;
    tick();
    check_reg("post_rst_mask", 2'd1, 32'h0);
    check_reg("post_rst_status", 2'd3, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/intctrl_vec.md
Name: intctrl_vec

Overview:
- Parametrised successor to the fixed interrupt encoder. Collects NSRC interrupt sources into one prioritised vector code for the bexkat2 `inter` input.
- Adds per-source masking, per-source level/edge mode, latched pending bits and an in-service state machine.
- Software reaches it through a Wishbone slave on the IO decoder (mmu_bus2).

Parameters:
- NSRC, 8: number of interrupt sources; legal range 1..32.
- VECW, 4: width of cpu_exception; must satisfy 2^VECW > NSRC.
- SYNC, 2: synchroniser flops per source input; legal range 2..3.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  asynchronous reset, active low.
- bus  if_wb.slave  32-bit data  register access.
- src  input  NSRC  raw interrupt requests, asynchronous to clk_i.
- enabled  input  1  CPU interrupt-enable (cpu int_en).
- cpu_exception  output  VECW  vector code to CPU; 0 means none.
- irq_pending  output  1  OR of all masked-eligible pending bits.

Behaviour:
- Reset, async on rst_ni low: all registers to 0; state IDLE; cpu_exception=0; irq_pending=0; bus.ack=0; synchronisers cleared.
- Input path: src passes through SYNC flops, giving s. A further flop s_d supports edge detection.
- Pending, level mode (MODE[i]=0): pend[i] follows s[i] each cycle. W1C has no effect.
- Pending, edge mode (MODE[i]=1): pend[i] is set on s & ~s_d. It is cleared by:
  - a PENDING write with data bit i = 1, or
  - the in-service clear described below.
- Pending, simultaneous set and clear in the same cycle: the set wins.
- Eligible: elig = pend & MASK. irq_pending = |elig, registered (1-cycle latency).
- Priority: the lowest set index of elig wins. Its code is index+1.
- FSM state IDLE:
  - cpu_exception=0.
  - If enabled=1 and elig≠0: latch vec = winning index+1; go to ASSERT.
- FSM state ASSERT:
  - cpu_exception=vec, registered.
  - Each cycle, recompute the winner.
  - If elig=0: go to IDLE.
  - If the winner changed to a higher priority: update vec.
  - If enabled falls to 0: clear pend[vec-1] if that source is edge mode; go to SERVICE.
- FSM state SERVICE:
  - cpu_exception=0.
  - When enabled returns to 1: go to IDLE. The next vector can appear 2 cycles later at the earliest.
- Timing: a new edge-mode interrupt with mask set and enabled=1 reaches cpu_exception SYNC+3 cycles after the src rise.
- Wishbone access:
  - Decode on bus.adr[3:2]. Respond with ack in the cycle after cyc&stb.
  - ack is held for one cycle only, never back-to-back for the same strobe.
  - bus.dat_o is valid with ack. Unused high bits read 0.
- Register 0, PENDING: read returns pend. Write is W1C on edge-mode bits.
- Register 1, MASK: read/write, reset 0.
- Register 2, MODE: read/write, reset 0.
- Register 3, STATUS: read-only.
  - [1:0] = state (IDLE=0, ASSERT=1, SERVICE=2).
  - [15:8] = vec.
  - Writes are ignored.
- Writes honour bus.sel byte enables. A MASK or MODE write takes effect on the cycle after ack.
- Mode change: switching a bit from edge to level makes pend follow the level immediately.
- Vector wrap: not possible given the VECW constraint. No saturation logic.

Test Plan:
- Reset, then MASK=0xFF, MODE=0xFF, enabled=1; pulse src[3] for 1 cycle -> cpu_exception=4 after SYNC+3 cycles; PENDING reads 0x08.
- From that state, drop enabled -> PENDING bit 3 clears, STATUS state=2, cpu_exception=0. Raise enabled -> state=0.
- src[5] and src[2] rise in the same cycle -> vector 3 first. After service and enabled=1 -> vector 6.
- Level mode, MASK=0x01, hold src[0]=1 -> vector 1. Write PENDING=0x01 -> no change. Deassert src[0] -> cpu_exception=0, state IDLE.
- Edge on src[1] in the same cycle as a PENDING W1C of bit 1 -> pend[1] remains 1.
- Assert rst_ni low while in ASSERT -> cpu_exception=0 and MASK=0 immediately, without waiting for a clock edge.
